// File: rtl/lsu_nb_pkg.sv
// Shared load/store op encodings, queue entry layout and data-path helpers.
// Purely combinational helpers; no latency of their own.
// No handshakes here; callers own all flow control.
package lsu_nb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } load_op_t;

  typedef enum logic [1:0] {
    SB = 2'd0,
    SH = 2'd1,
    SW = 2'd2
  } store_op_t;

  // One outstanding load: where the result goes and how to slice it.
  typedef struct packed {
    logic [4:0] rd;
    load_op_t   load_op;
    logic [1:0] offset;
  } lsu_entry_t;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always fine.
  function automatic logic is_misaligned(input logic is_load, input logic is_store,
                                         input load_op_t lop, input store_op_t sop,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (is_load) begin
      if ((lop == LH || lop == LHU) && off[0]) mis = 1'b1;
      if (lop == LW && off != 2'b00)           mis = 1'b1;
    end else if (is_store) begin
      if (sop == SH && off[0])        mis = 1'b1;
      if (sop == SW && off != 2'b00)  mis = 1'b1;
    end
    return mis;
  endfunction

  // Pick the addressed byte/half out of the raw word and extend it.
  function automatic logic [31:0] load_extend(input load_op_t op, input logic [1:0] off,
                                              input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = raw[8*off +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    case (op)
      LB:      res = {{24{b[7]}}, b};
      LBU:     res = {24'd0, b};
      LH:      res = {{16{h[15]}}, h};
      LHU:     res = {16'd0, h};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_nb_ld_queue.sv
// In-order circular queue of outstanding load descriptors with per-slot valid vector.
// Push/pop take effect at the clock edge; head and valid vector come straight from state.
// Push is dropped when full and pop when empty; callers gate with o_full/o_empty.
module lsu_nb_ld_queue
  import lsu_nb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  lsu_entry_t       i_push_dat,
  input  logic             i_pop,
  output lsu_entry_t       o_head_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [DEPTH-1:0] o_ent_vld,
  output lsu_entry_t       o_ent [DEPTH]
);
  localparam int PW = $clog2(DEPTH);

  lsu_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == (PW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_ent      = r_mem;

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; validity lives entirely in the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    o_ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_vld[i] = ({1'b0, PW'(i) - r_rd_ptr} < r_count);
    end
  end

endmodule

// File: rtl/lsu_nb.sv
// Non-blocking LSU: issues one op per cycle to the data port, tracks up to DEPTH loads in order.
// Issue is combinational pass-through; load writeback is 1 cycle after d_rsp_valid.
// Loads stall (req_ready=0) on a full queue or d_req_ready=0; stores only on d_req_ready=0.
module lsu_nb
  import lsu_nb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic            req_is_store,
  input  load_op_t        req_load_op,
  input  store_op_t       req_store_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            d_req_valid,
  input  logic            d_req_ready,
  output logic [XLEN-1:0] d_addr,
  output logic [3:0]      d_we,
  output logic [XLEN-1:0] d_wr_data,
  input  logic            d_rsp_valid,
  input  logic [XLEN-1:0] d_rd_data,
  output logic            ld_valid,
  output logic [4:0]      ld_rd,
  output logic [XLEN-1:0] ld_rd_data,
  output logic [31:0]     pending_mask,
  output logic            err_valid,
  output logic [XLEN-1:0] err_addr
);
  logic             w_mis;
  logic             w_ld_block;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  lsu_entry_t       w_push_dat;
  lsu_entry_t       w_head;
  logic [DEPTH-1:0] w_ent_vld;
  lsu_entry_t       w_ent [DEPTH];

  logic             r_ld_valid;
  logic [4:0]       r_ld_rd;
  logic [XLEN-1:0]  r_ld_rd_data;
  logic             r_err_valid;
  logic [XLEN-1:0]  r_err_addr;

  assign w_mis      = is_misaligned(req_is_load, req_is_store, req_load_op, req_store_op, req_addr[1:0]);
  assign w_ld_block = req_is_load & w_full;

  assign d_req_valid = req_valid & (req_is_load | req_is_store) & ~w_mis & ~w_ld_block;
  assign req_ready   = w_mis | (d_req_ready & ~w_ld_block);
  assign d_addr      = {req_addr[XLEN-1:2], 2'b00};

  assign w_push     = d_req_valid & d_req_ready & req_is_load;
  assign w_pop      = d_rsp_valid & ~w_empty;
  assign w_push_dat = '{rd: req_rd, load_op: req_load_op, offset: req_addr[1:0]};

  // Store lane enables and replicated data; loads drive no enables.
  always_comb begin
    d_we      = 4'b0000;
    d_wr_data = '0;
    if (req_is_store && !req_is_load) begin
      case (req_store_op)
        SB: begin
          d_we      = 4'b0001 << req_addr[1:0];
          d_wr_data = {4{req_wdata[7:0]}};
        end
        SH: begin
          d_we      = 4'b0011 << req_addr[1:0];
          d_wr_data = {2{req_wdata[15:0]}};
        end
        default: begin
          d_we      = 4'b1111;
          d_wr_data = req_wdata;
        end
      endcase
    end
  end

  lsu_nb_ld_queue #(.DEPTH(DEPTH)) u_ld_queue (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_ent_vld  (w_ent_vld),
    .o_ent      (w_ent)
  );

  // Writeback register: extend the head entry's data when its response lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_valid   <= 1'b0;
      r_ld_rd      <= '0;
      r_ld_rd_data <= '0;
    end else begin
      r_ld_valid <= w_pop & (w_head.rd != 5'd0);
      if (w_pop) begin
        r_ld_rd      <= w_head.rd;
        r_ld_rd_data <= load_extend(w_head.load_op, w_head.offset, d_rd_data);
      end
    end
  end

  // Misaligned ops are swallowed and reported one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_err_valid <= req_valid & w_mis;
      if (req_valid && w_mis) r_err_addr <= req_addr;
    end
  end

  // RAW-hazard mask: every queued destination plus the one in writeback.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i]) pending_mask[w_ent[i].rd] = 1'b1;
    end
    if (r_ld_valid) pending_mask[r_ld_rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign ld_valid   = r_ld_valid;
  assign ld_rd      = r_ld_rd;
  assign ld_rd_data = r_ld_rd_data;
  assign err_valid  = r_err_valid;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_lsu_nb.sv
// Directed self-checking bench for lsu_nb: stores, load extension, queue full, misalign, reset.
// Inputs change 1ns after posedge; combinational outputs checked at negedge.
// Registered outputs checked 1ns after the edge that updates them.
module tb_lsu_nb;
  import lsu_nb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_load = 1'b0;
  logic        req_is_store = 1'b0;
  load_op_t    req_load_op = LW;
  store_op_t   req_store_op = SW;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        d_req_valid;
  logic        d_req_ready = 1'b0;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wr_data;
  logic        d_rsp_valid = 1'b0;
  logic [31:0] d_rd_data = '0;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_rd_data;
  logic [31:0] pending_mask;
  logic        err_valid;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;
  int outstanding = 0;
  int stray = 0;

  always #5 clk = ~clk;

  lsu_nb #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_load_op(req_load_op), .req_store_op(req_store_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_addr(d_addr), .d_we(d_we), .d_wr_data(d_wr_data),
    .d_rsp_valid(d_rsp_valid), .d_rd_data(d_rd_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_rd_data(ld_rd_data),
    .pending_mask(pending_mask),
    .err_valid(err_valid), .err_addr(err_addr)
  );

  // Bench-side count of accepted loads; responses arriving with none pending are tallied as stray.
  always @(posedge clk or negedge rst) begin
    if (!rst) outstanding <= 0;
    else outstanding <= outstanding + ((d_req_valid && d_req_ready && req_is_load) ? 1 : 0)
                                    - ((d_rsp_valid && outstanding != 0) ? 1 : 0);
  end
  always @(posedge clk) begin
    if (rst && d_rsp_valid && outstanding == 0) stray <= stray + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req_valid = 0; req_is_load = 0; req_is_store = 0;
  endtask

  task automatic drv_load(input load_op_t op, input logic [4:0] rd, input logic [31:0] addr);
    req_valid = 1; req_is_load = 1; req_is_store = 0;
    req_load_op = op; req_rd = rd; req_addr = addr;
  endtask

  task automatic drv_store(input store_op_t op, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1; req_is_load = 0; req_is_store = 1;
    req_store_op = op; req_addr = addr; req_wdata = data;
  endtask

  // Store: check the combinational issue, then confirm nothing was queued.
  task automatic do_store(input string tag, input store_op_t op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd);
    drv_store(op, addr, data);
    @(negedge clk);
    chk({tag, "_dvld"}, 32'(d_req_valid), 32'd1);
    chk({tag, "_rdy"},  32'(req_ready), 32'd1);
    chk({tag, "_we"},   32'(d_we), 32'(exp_we));
    chk({tag, "_addr"}, d_addr, {addr[31:2], 2'b00});
    chk({tag, "_wd"},   d_wr_data, exp_wd);
    step;
    idle;
    chk({tag, "_nopend"}, pending_mask, 32'd0);
  endtask

  // Single load: issue, respond with raw, check writeback one cycle later and mask lifetime.
  task automatic do_load(input string tag, input load_op_t op, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] raw,
                         input logic [31:0] exp_data);
    logic [31:0] m;
    m = (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
    drv_load(op, rd, addr);
    @(negedge clk);
    chk({tag, "_dvld"}, 32'(d_req_valid), 32'd1);
    chk({tag, "_we"},   32'(d_we), 32'd0);
    chk({tag, "_addr"}, d_addr, {addr[31:2], 2'b00});
    step;
    idle;
    chk({tag, "_pend_q"}, pending_mask, m);
    d_rsp_valid = 1; d_rd_data = raw;
    step;
    d_rsp_valid = 0;
    chk({tag, "_ldv"}, 32'(ld_valid), (rd == 5'd0) ? 32'd0 : 32'd1);
    chk({tag, "_ldrd"}, 32'(ld_rd), 32'(rd));
    if (rd != 5'd0) chk({tag, "_data"}, ld_rd_data, exp_data);
    chk({tag, "_pend_wb"}, pending_mask, m);
    step;
    chk({tag, "_ldv_off"}, 32'(ld_valid), 32'd0);
    chk({tag, "_pend_clr"}, pending_mask, 32'd0);
  endtask

  logic [4:0]  rd_seq [4];
  logic [31:0] raw_k;

  initial begin
    // Reset state
    step; step;
    chk("rst_ldv", 32'(ld_valid), 32'd0);
    chk("rst_ldrd", 32'(ld_rd), 32'd0);
    chk("rst_lddata", ld_rd_data, 32'd0);
    chk("rst_errv", 32'(err_valid), 32'd0);
    chk("rst_erra", err_addr, 32'd0);
    chk("rst_pend", pending_mask, 32'd0);
    chk("rst_dvld", 32'(d_req_valid), 32'd0);
    rst = 1;
    d_req_ready = 1;
    step;

    // Store lanes
    do_store("sw", SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_store("sb", SB, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    do_store("sh", SH, 32'h102, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("sb1", SB, 32'h101, 32'hFFFFFF3C, 4'b0010, 32'h3C3C3C3C);

    // Load extension
    do_load("lb",  LB,  5'd5, 32'h102, 32'h80FF0000, 32'hFFFFFFFF);
    do_load("lbu", LBU, 5'd5, 32'h102, 32'h80FF0000, 32'h000000FF);
    do_load("lb3", LB,  5'd6, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lh",  LH,  5'd6, 32'h102, 32'h80FF0000, 32'hFFFF80FF);
    do_load("lhu", LHU, 5'd9, 32'h100, 32'h12348000, 32'h00008000);
    do_load("lw",  LW,  5'd31, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);
    do_load("lwx0", LW, 5'd0, 32'h108, 32'hAAAA5555, 32'h0);

    // Fill queue, then check full behaviour
    for (int i = 1; i <= 4; i++) begin
      drv_load(LW, 5'(i), 32'h200 + 32'(4 * i));
      step;
    end
    drv_load(LW, 5'd8, 32'h220);
    @(negedge clk);
    chk("full_rdy", 32'(req_ready), 32'd0);
    chk("full_dvld", 32'(d_req_valid), 32'd0);
    chk("full_pend", pending_mask, 32'h0000001E);
    step;
    drv_store(SW, 32'h500, 32'h1);
    @(negedge clk);
    chk("full_st_rdy", 32'(req_ready), 32'd1);
    chk("full_st_dvld", 32'(d_req_valid), 32'd1);
    step;
    drv_load(LW, 5'd8, 32'h220);
    d_rsp_valid = 1; d_rd_data = 32'h11111111;
    @(negedge clk);
    chk("nobypass_rdy", 32'(req_ready), 32'd0);
    step;
    d_rsp_valid = 0;
    chk("pop1_ldv", 32'(ld_valid), 32'd1);
    chk("pop1_rd", 32'(ld_rd), 32'd1);
    chk("pop1_data", ld_rd_data, 32'h11111111);
    @(negedge clk);
    chk("freed_rdy", 32'(req_ready), 32'd1);
    chk("freed_dvld", 32'(d_req_valid), 32'd1);
    step;
    idle;
    chk("q_pend", pending_mask, 32'h0000011C);
    rd_seq[0] = 5'd2; rd_seq[1] = 5'd3; rd_seq[2] = 5'd4; rd_seq[3] = 5'd8;
    for (int k = 0; k < 4; k++) begin
      raw_k = 32'h01010101 * 32'(k + 2);
      d_rsp_valid = 1; d_rd_data = raw_k;
      step;
      chk("drain_ldv", 32'(ld_valid), 32'd1);
      chk("drain_rd", 32'(ld_rd), 32'(rd_seq[k]));
      chk("drain_data", ld_rd_data, raw_k);
    end
    d_rsp_valid = 0;
    step;
    chk("drain_pend", pending_mask, 32'd0);
    chk("drain_ldv_off", 32'(ld_valid), 32'd0);

    // Misaligned accesses
    drv_load(LW, 5'd9, 32'h102);
    @(negedge clk);
    chk("mis_lw_dvld", 32'(d_req_valid), 32'd0);
    chk("mis_lw_rdy", 32'(req_ready), 32'd1);
    step;
    idle;
    chk("mis_lw_errv", 32'(err_valid), 32'd1);
    chk("mis_lw_erra", err_addr, 32'h102);
    chk("mis_lw_pend", pending_mask, 32'd0);
    step;
    chk("mis_errv_off", 32'(err_valid), 32'd0);
    drv_store(SH, 32'h101, 32'h5555);
    @(negedge clk);
    chk("mis_sh_dvld", 32'(d_req_valid), 32'd0);
    step;
    idle;
    chk("mis_sh_errv", 32'(err_valid), 32'd1);
    chk("mis_sh_erra", err_addr, 32'h101);
    step;

    // Reset mid-flight
    drv_load(LW, 5'd7, 32'h300); step;
    drv_load(LW, 5'd7, 32'h304); step;
    idle;
    d_rsp_valid = 1; d_rd_data = 32'h77777777;
    step;
    d_rsp_valid = 0;
    chk("two7_pend", pending_mask, 32'h00000080);
    chk("two7_ldv", 32'(ld_valid), 32'd1);
    #2 rst = 0;
    #1;
    chk("arst_pend", pending_mask, 32'd0);
    chk("arst_ldv", 32'(ld_valid), 32'd0);
    chk("arst_lddata", ld_rd_data, 32'd0);
    chk("arst_erra", err_addr, 32'd0);
    step; step;
    rst = 1;
    d_rsp_valid = 1; d_rd_data = 32'h12345678;
    step;
    d_rsp_valid = 0;
    chk("late_ldv", 32'(ld_valid), 32'd0);
    chk("late_pend", pending_mask, 32'd0);
    chk("late_lddata", ld_rd_data, 32'd0);
    step;
    do_load("post_rst", LW, 5'd10, 32'h400, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("stray_rsp", 32'(stray), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
